// File: rtl/countdown_zero_timer.sv
// Loadable down-counter: counts an accepted value to zero under i_enable and pulses o_done on terminal count.
// Latency: the load is visible one cycle after acceptance; o_done is a registered pulse one cycle after the terminal edge.
// Backpressure: o_load_ready is low while RUN, and the source holds i_load_valid until the timer returns to IDLE.
module countdown_zero_timer #(
  parameter int BUS_WIDTH   = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load_valid,
  output logic                 o_load_ready,
  input  logic [BUS_WIDTH-1:0] i_load_value,
  input  logic                 i_enable,
  input  logic                 i_abort,
  output logic [BUS_WIDTH-1:0] o_count,
  output logic                 o_zero,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] count_q, count_d;
  logic [BUS_WIDTH-1:0] reload_q, reload_d;
  logic                 done_q, done_d;
  logic                 load_fire;
  logic                 at_one;

  assign o_load_ready = (state_q == IDLE);
  assign load_fire    = i_load_valid && o_load_ready;
  // Terminal is detected at 1, so the decrement can never wrap below zero.
  assign at_one       = (count_q == BUS_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_fire) begin
          reload_d = i_load_value;
          if (i_load_value == '0) begin
            // A zero load expires immediately without entering RUN.
            count_d = '0;
            done_d  = 1'b1;
          end else begin
            count_d = i_load_value;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (i_enable) begin
          if (at_one) begin
            done_d = 1'b1;
            if (AUTO_RELOAD) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - BUS_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign o_count = count_q;
  assign o_zero  = (count_q == '0);
  assign o_busy  = (state_q == RUN);
  assign o_done  = done_q;

endmodule

// File: tb/tb_countdown_zero_timer.sv
// Bench for countdown_zero_timer: two instances (one-shot and auto-reload) share the stimulus and are checked against a per-cycle model.
module tb_countdown_zero_timer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, load_valid, enable, abort;
  logic [W-1:0] load_value;

  logic [W-1:0] c0, c1;
  logic         z0, z1, b0, b1, r0, r1, d0, d1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state, indexed by instance: 0 = one-shot, 1 = auto-reload
  logic [W-1:0] m_cnt[2];
  logic [W-1:0] m_rel[2];
  bit           m_busy[2];
  bit           m_done[2];

  int exp5[5]  = '{4, 3, 2, 1, 0};
  int pat3[5]  = '{1, 0, 1, 0, 1};
  int exp3[5]  = '{2, 2, 1, 1, 0};
  int expa[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};

  always #5 clk = ~clk;

  countdown_zero_timer #(.BUS_WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid), .o_load_ready(r0),
    .i_load_value(load_value), .i_enable(enable), .i_abort(abort),
    .o_count(c0), .o_zero(z0), .o_busy(b0), .o_done(d0)
  );

  countdown_zero_timer #(.BUS_WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid), .o_load_ready(r1),
    .i_load_value(load_value), .i_enable(enable), .i_abort(abort),
    .o_count(c1), .o_zero(z1), .o_busy(b1), .o_done(d1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies the timer rules to the inputs present at the edge.
  task automatic model_edge(input int u);
    if (rst) begin
      m_cnt[u] = '0; m_rel[u] = '0; m_busy[u] = 0; m_done[u] = 0;
    end else begin
      m_done[u] = 0;
      if (!m_busy[u]) begin
        if (load_valid) begin
          m_rel[u] = load_value;
          m_cnt[u] = load_value;
          if (load_value == 0) m_done[u] = 1;
          else m_busy[u] = 1;
        end
      end else if (abort) begin
        m_busy[u] = 0;
        m_cnt[u]  = '0;
      end else if (enable) begin
        if (m_cnt[u] == 1) begin
          m_done[u] = 1;
          if (u == 1) m_cnt[u] = m_rel[u];
          else begin
            m_cnt[u]  = '0;
            m_busy[u] = 0;
          end
        end else begin
          m_cnt[u] = m_cnt[u] - 1;
        end
      end
    end
  endtask

  task automatic check_unit(input int u, input logic [W-1:0] c, input logic z, input logic b,
                            input logic r, input logic d);
    chk($sformatf("model_count%0d", u), c, m_cnt[u]);
    chk($sformatf("model_zero%0d", u), z, m_cnt[u] == 0);
    chk($sformatf("model_busy%0d", u), b, m_busy[u]);
    chk($sformatf("model_ready%0d", u), r, !m_busy[u]);
    chk($sformatf("model_done%0d", u), d, m_done[u]);
  endtask

  // One clock: advance the model on the edge, then compare both instances #1 later.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_unit(0, c0, z0, b0, r0, d0);
    check_unit(1, c1, z1, b1, r1, d1);
  endtask

  task automatic do_reset();
    rst = 1'b1; load_valid = 1'b0; abort = 1'b0; enable = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int busy_n, pulses, n;
    rst = 1'b1; load_valid = 1'b0; load_value = '0; enable = 1'b0; abort = 1'b0;

    // Reset overrides a pending load and enable
    load_valid = 1'b1; enable = 1'b1; load_value = 8'd9;
    step(); step();
    chk("rst_count", c0, 0);
    chk("rst_zero", z0, 1);
    chk("rst_busy", b0, 0);
    chk("rst_done", d0, 0);
    chk("rst_ready", r0, 1);
    chk("rst_count_auto", c1, 0);

    // Load 5, enable high throughout
    rst = 1'b0; load_value = 8'd5;
    step();
    load_valid = 1'b0;
    chk("seq5_load", c0, 5);
    busy_n = b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("seq5_count", c0, exp5[i]);
      chk("seq5_done", d0, i == 4);
      busy_n += b0;
    end
    chk("seq5_busy_cycles", busy_n, 5);

    // Load 3 with toggling enable, then back-to-back load 2 in the done cycle
    do_reset();
    load_valid = 1'b1; load_value = 8'd3; enable = 1'b1;
    step();
    load_valid = 1'b0;
    chk("tog_load", c0, 3);
    for (int i = 0; i < 5; i++) begin
      enable = pat3[i][0];
      step();
      chk("tog_count", c0, exp3[i]);
    end
    chk("tog_done", d0, 1);
    load_valid = 1'b1; load_value = 8'd2; enable = 1'b1;
    step();
    load_valid = 1'b0;
    chk("b2b_load", c0, 2);
    step();
    chk("b2b_count1", c0, 1);
    step();
    chk("b2b_count0", c0, 0);
    chk("b2b_done", d0, 1);

    // Zero load, then full-range load
    do_reset();
    load_valid = 1'b1; load_value = 8'd0;
    step();
    load_valid = 1'b0;
    chk("zero_busy", b0, 0);
    chk("zero_done", d0, 1);
    chk("zero_done_auto", d1, 1);
    step();
    chk("zero_done_clear", d0, 0);
    load_valid = 1'b1; load_value = 8'd255; enable = 1'b1;
    step();
    load_valid = 1'b0;
    n = 0;
    while (!d0 && n < 400) begin
      step();
      n++;
    end
    chk("load255_cycles", n, 255);

    // Abort at count 1 with enable, load held off while RUN
    do_reset();
    load_valid = 1'b1; load_value = 8'd4; enable = 1'b1;
    step();
    load_valid = 1'b0;
    step(); step();
    load_valid = 1'b1; load_value = 8'd7;
    step();
    chk("abort_pre_count", c0, 1);
    chk("abort_ready_low", r0, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_count", c0, 0);
    chk("abort_busy", b0, 0);
    chk("abort_no_done", d0, 0);
    step();
    load_valid = 1'b0;
    chk("held_load_count", c0, 7);
    chk("held_load_busy", b0, 1);

    // Auto-reload period 3
    do_reset();
    load_valid = 1'b1; load_value = 8'd3; enable = 1'b1;
    step();
    load_valid = 1'b0;
    chk("auto_load", c1, 3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("auto_count", c1, expa[i]);
      chk("auto_busy", b1, 1);
      pulses += d1;
    end
    chk("auto_pulses", pulses, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("auto_abort_count", c1, 0);
    chk("auto_abort_busy", b1, 0);
    chk("auto_abort_done", d1, 0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      load_valid = ($urandom_range(0, 2) == 0);
      load_value = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      enable     = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_zero_timer.md
# countdown_zero_timer

Loadable down-counter with a valid/ready load handshake that counts an accepted value down to zero under a count-enable and reports terminal count. It complements the combinational zero detector in the arithmetic library: that block tests whether a bus is zero; this block produces a bus that reaches zero after a programmed number of enabled cycles. Used as a delay, watchdog, or periodic tick source by control logic.

## Interface

- BUS_WIDTH, 8, width of load value and counter (≥ 2)
- AUTO_RELOAD, 0, 1 = reload the stored value on terminal count and keep running

- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_load_valid  input  1  load request
- o_load_ready  output  1  load can be accepted (state IDLE)
- i_load_value  input  BUS_WIDTH  start value, sampled when i_load_valid && o_load_ready
- i_enable  input  1  decrement enable while RUN
- i_abort  input  1  cancel a running count
- o_count  output  BUS_WIDTH  current counter value (registered)
- o_zero  output  1  o_count == 0 (combinational from register)
- o_busy  output  1  state RUN
- o_done  output  1  one-cycle registered terminal-count pulse

## Operation

- States: IDLE, RUN. Stored reload register `reload_q` (BUS_WIDTH).
- Reset (i_rst high at edge): state IDLE, o_count 0, reload_q 0, o_done 0. Hence o_busy 0, o_zero 1, o_load_ready 1. Reset overrides all other inputs.
- o_load_ready = (state == IDLE). Loads offered in RUN are ignored; the source must hold i_load_valid until ready.
- IDLE, handshake fires, value N:
  - N == 0: stay IDLE, o_count 0, o_done pulses next cycle, reload_q = 0.
  - N > 0: o_count = N, reload_q = N, go RUN.
- IDLE, no handshake: hold o_count; i_enable and i_abort ignored.
- RUN, priority: i_abort > decrement.
  - i_abort: go IDLE, o_count 0, no o_done.
  - i_enable and o_count > 1: o_count − 1.
  - i_enable and o_count == 1: terminal. o_done = 1 next cycle.
    - AUTO_RELOAD = 0: o_count 0, go IDLE.
    - AUTO_RELOAD = 1: o_count = reload_q, stay RUN.
  - !i_enable: hold.
- Decrement is modulo-free: o_count never wraps below 0 because terminal is detected at 1.
- o_done is 0 in every cycle not directly following a terminal event or a zero load.

## Timing

- Load accepted at edge k: o_count = N, o_busy = 1 visible after edge k.
- With i_enable held high: o_count = N − j after edge k + j. Terminal at edge k + N: o_done = 1, o_count = 0, o_busy = 0, o_load_ready = 1 in the same cycle (AUTO_RELOAD = 0). Busy lasts exactly N cycles.
- Back-to-back: a load presented in the o_done cycle is accepted at that edge, so there is no idle gap.
- AUTO_RELOAD = 1: o_done pulses every N enabled cycles. o_count cycles N, N−1, …, 1, N. o_busy stays 1 and o_zero stays 0 until abort.
- Abort and terminal in the same cycle: abort wins. No o_done, state IDLE.
- Reset mid-RUN: next cycle matches post-reset values. No o_done.
- Maximum load 2^BUS_WIDTH − 1 is valid and counts the full range.

## Test plan

- Reset with i_load_valid = 1 and i_enable = 1 → o_count 0, o_zero 1, o_busy 0, o_done 0, o_load_ready 1. The load is not accepted.
- BUS_WIDTH = 8, load 5, i_enable always 1 → o_count 5,4,3,2,1,0 on consecutive cycles. o_done is high only in the 0 cycle. o_busy is high for exactly 5 cycles.
- Load 3 with i_enable toggling 1,0,1,0,1 → o_count 3,2,2,1,1,0. A second load in the o_done cycle (value 2) is accepted immediately, giving 2,1,0.
- Load 0 → o_busy stays 0 and a single o_done pulse appears the next cycle. Load 255 → terminal after exactly 255 enabled cycles.
- Load 4, assert i_abort when o_count = 1 together with i_enable → o_count 0, IDLE, no o_done. Load offered while RUN is held off (o_load_ready 0) and accepted at the first IDLE cycle.
- AUTO_RELOAD = 1, load 3, i_enable high for 10 cycles → o_count 3,2,1,3,2,1,3,…. o_done pulses on each wrap to 3 (3 pulses). Abort then gives o_count 0 and o_busy 0.
